// File: rtl/pcap_replay_fifo_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcap_replay_fifo_wr_arb_pkg
// Description : Shared definitions for the pcap replay FIFO write arbiter:
//               FSM state encoding and an index-width helper used to size
//               the round-robin pointer and the grant register.
// Config      : PCAP_REPLAY_FIFO_WR_ARB_PAD_EN (ST_PAD is only reachable
//               when defined)
// Revision    : 1.0 - initial release
// ============================================================================
package pcap_replay_fifo_wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_PAD    = 2'd2
    } state_t;

    // Width of an index that can address 'value' entries (minimum 1 bit).
    function automatic int log2_ceil(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage : pcap_replay_fifo_wr_arb_pkg
`default_nettype wire

// File: rtl/pcap_replay_fifo_wr_arb_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : pcap_replay_fifo_wr_arb_rr_select
// Description : Combinational round-robin pick. Returns the first requesting
//               queue at or after ptr, wrapping modulo NUM_QUEUES.
// Ports       : req  - per-queue request vector
//               ptr  - round-robin start position
//               any  - at least one request present
//               idx  - selected queue (0 when any=0)
// Config      : PCAP_REPLAY_FIFO_WR_ARB_PAD_EN has no effect on this module
// Revision    : 1.0 - initial release
// ============================================================================
module pcap_replay_fifo_wr_arb_rr_select
    import pcap_replay_fifo_wr_arb_pkg::*;
#(
    parameter int NUM_QUEUES = 4,
    parameter int IDX_W      = log2_ceil(NUM_QUEUES)
) (
    input  logic [NUM_QUEUES-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic                  any,
    output logic [IDX_W-1:0]      idx
);

    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down to offset 0 so the candidate
    // closest to ptr is the last one written and therefore wins.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
            w_cand = IDX_W'((int'(ptr) + k) % NUM_QUEUES);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule : pcap_replay_fifo_wr_arb_rr_select
`default_nettype wire

// File: rtl/pcap_replay_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : pcap_replay_fifo_wr_arb
// Description : Packet-granular round-robin arbiter sharing the write port of
//               the 144-to-288 async FIFO among NUM_QUEUES replay queues.
//               Packets are never interleaved; odd-length packets get one
//               all-zero pad beat so each 288-bit read word holds a single
//               packet. New packets are only admitted while prog_full is low.
// Ports       : clk, rst          - write clock, sync active-high reset
//               in_valid/in_last  - per-queue beat valid / end of packet
//               in_data           - per-queue beats, queue i at [i*DW +: DW]
//               in_ready          - per-queue beat accept
//               fifo_wr_en/din    - FIFO write port (zero latency)
//               fifo_full         - throttles every write
//               fifo_prog_full    - blocks new grants (sampled in IDLE)
//               pkt_count         - completed packets (wraps)
//               pad_count         - inserted pad beats (wraps)
// Config      : PCAP_REPLAY_FIFO_WR_ARB_PAD_EN - defined: odd-length padding
//               enabled; undefined: no PAD state, pad_count tied to 0
// Revision    : 1.0 - initial release
// ============================================================================
module pcap_replay_fifo_wr_arb
    import pcap_replay_fifo_wr_arb_pkg::*;
#(
    parameter int NUM_QUEUES = 4,
    parameter int DATA_WIDTH = 144,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_QUEUES-1:0]            in_valid,
    input  logic [NUM_QUEUES-1:0]            in_last,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    output logic [NUM_QUEUES-1:0]            in_ready,
    output logic                             fifo_wr_en,
    output logic [DATA_WIDTH-1:0]            fifo_din,
    input  logic                             fifo_full,
    input  logic                             fifo_prog_full,
    output logic [CNT_WIDTH-1:0]             pkt_count,
    output logic [CNT_WIDTH-1:0]             pad_count
);

    localparam int                c_IDX_W  = log2_ceil(NUM_QUEUES);
    localparam logic [c_IDX_W-1:0] c_LAST_Q = c_IDX_W'(NUM_QUEUES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   r_grant;
    logic [c_IDX_W-1:0]   w_grant_inc;
    logic [CNT_WIDTH-1:0] r_pkt_count;

    logic                 w_any;
    logic [c_IDX_W-1:0]   w_sel_idx;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [DATA_WIDTH-1:0] w_q_data [NUM_QUEUES];

    logic                 w_beat;
    logic                 w_grant_load;
    logic                 w_ptr_load;
    logic                 w_pkt_done;

`ifdef PCAP_REPLAY_FIFO_WR_ARB_PAD_EN
    logic                 r_parity;     // 1 after an odd number of beats
    logic                 w_pad_beat;
    logic [CNT_WIDTH-1:0] r_pad_count;
`endif

    // ------------------------------------------------------------------
    // Per-queue data unpack and granted-queue mux
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_unpack
            assign w_q_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_sel_valid = in_valid[r_grant];
    assign w_sel_last  = in_last[r_grant];
    assign w_sel_data  = w_q_data[r_grant];
    assign w_grant_inc = (r_grant == c_LAST_Q) ? '0 : r_grant + 1'b1;

    // A beat moves only in STREAM, only from the granted queue, only with room.
    assign w_beat = (r_state == ST_STREAM) && w_sel_valid && !fifo_full;

    pcap_replay_fifo_wr_arb_rr_select #(
        .NUM_QUEUES (NUM_QUEUES),
        .IDX_W      (c_IDX_W)
    ) u_rr_select (
        .req (in_valid),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_sel_idx)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        in_ready     = '0;
        fifo_wr_en   = 1'b0;
        fifo_din     = '0;
        w_grant_load = 1'b0;
        w_ptr_load   = 1'b0;
        w_pkt_done   = 1'b0;
`ifdef PCAP_REPLAY_FIFO_WR_ARB_PAD_EN
        w_pad_beat   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!fifo_prog_full && w_any) begin
                    w_grant_load = 1'b1;
                    w_state_nxt  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                in_ready[r_grant] = !fifo_full;
                if (w_beat) begin
                    fifo_wr_en = 1'b1;
                    fifo_din   = w_sel_data;
                    if (w_sel_last) begin
                        w_ptr_load = 1'b1;
`ifdef PCAP_REPLAY_FIFO_WR_ARB_PAD_EN
                        // Parity still reflects the beats before this one:
                        // an even count so far means this packet is odd.
                        if (!r_parity) begin
                            w_state_nxt = ST_PAD;
                        end else begin
                            w_pkt_done  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
`else
                        w_pkt_done  = 1'b1;
                        w_state_nxt = ST_IDLE;
`endif
                    end
                end
            end
`ifdef PCAP_REPLAY_FIFO_WR_ARB_PAD_EN
            ST_PAD: begin
                if (!fifo_full) begin
                    fifo_wr_en  = 1'b1;
                    w_pad_beat  = 1'b1;
                    w_pkt_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant, round-robin pointer and packet counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_grant     <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_grant_load) begin
                r_grant <= w_sel_idx;
            end
            if (w_ptr_load) begin
                r_ptr <= w_grant_inc;
            end
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
        end
    end

    assign pkt_count = r_pkt_count;

`ifdef PCAP_REPLAY_FIFO_WR_ARB_PAD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity    <= 1'b0;
            r_pad_count <= '0;
        end else begin
            if (w_grant_load) begin
                r_parity <= 1'b0;
            end else if (w_beat) begin
                r_parity <= ~r_parity;
            end
            if (w_pad_beat) begin
                r_pad_count <= r_pad_count + CNT_WIDTH'(1);
            end
        end
    end

    assign pad_count = r_pad_count;
`else
    assign pad_count = '0;
`endif

endmodule : pcap_replay_fifo_wr_arb
`default_nettype wire

// File: tb/tb_pcap_replay_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcap_replay_fifo_wr_arb
// Description : Directed self-checking bench for pcap_replay_fifo_wr_arb.
//               Per-queue packet sources drive the DUT; every FIFO write is
//               logged and compared with a hand-built expected write list.
// Config      : PCAP_REPLAY_FIFO_WR_ARB_PAD_EN selects the padded or the
//               unpadded expectations
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcap_replay_fifo_wr_arb;

    localparam int NQ = 4;
    localparam int DW = 144;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NQ-1:0]    in_valid;
    logic [NQ-1:0]    in_last;
    logic [NQ*DW-1:0] in_data;
    logic [NQ-1:0]    in_ready;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_din;
    logic             fifo_full;
    logic             fifo_prog_full;
    logic [CW-1:0]    pkt_count;
    logic [CW-1:0]    pad_count;

    // Packet sources
    int  src_npkt [NQ];
    int  src_len  [NQ];
    int  src_beat [NQ];
    int  src_pidx [NQ];
    bit  src_hold [NQ];

    logic [DW-1:0] wr_log  [$];
    logic [DW-1:0] exp_log [$];
    int            wr_cyc  [$];

    int            cyc;
    int            full_viol;
    int            multi_ready;
    int            mask_viol;
    logic [NQ-1:0] allowed;
    int            n_checks;
    int            n_errors;
    int            cyc_d;

    pcap_replay_fifo_wr_arb #(
        .NUM_QUEUES (NQ),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_din       (fifo_din),
        .fifo_full      (fifo_full),
        .fifo_prog_full (fifo_prog_full),
        .pkt_count      (pkt_count),
        .pad_count      (pad_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input int q, input int p, input int b);
        logic [31:0] t;
        t = {8'hA5, q[7:0], p[7:0], b[7:0]};
        return DW'(t);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int q = 0; q < NQ; q++) begin
            in_valid[q]          = (src_npkt[q] > 0) && !src_hold[q];
            in_last[q]           = (src_beat[q] == src_len[q] - 1);
            in_data[q*DW +: DW]  = mk(q, src_pidx[q], src_beat[q]);
        end
    endtask

    function automatic int pending();
        int n;
        n = 0;
        for (int q = 0; q < NQ; q++) n += src_npkt[q];
        return n;
    endfunction

    // One clock: observe at negedge, advance sources after posedge.
    task automatic tick();
        bit acc [NQ];
        @(negedge clk);
        if (fifo_wr_en) begin
            wr_log.push_back(fifo_din);
            wr_cyc.push_back(cyc);
        end
        if (fifo_full && (fifo_wr_en || in_ready != '0)) full_viol++;
        if ($countones(in_ready) > 1) multi_ready++;
        if ((in_ready & ~allowed) != '0) mask_viol++;
        for (int q = 0; q < NQ; q++) acc[q] = in_valid[q] && in_ready[q];
        @(posedge clk);
        cyc++;
        #1;
        for (int q = 0; q < NQ; q++) begin
            if (acc[q]) begin
                src_beat[q]++;
                if (src_beat[q] == src_len[q]) begin
                    src_beat[q] = 0;
                    src_pidx[q]++;
                    src_npkt[q]--;
                end
            end
        end
        drive();
    endtask

    task automatic clear_src();
        for (int q = 0; q < NQ; q++) begin
            src_npkt[q] = 0;
            src_len[q]  = 1;
            src_beat[q] = 0;
            src_pidx[q] = 0;
            src_hold[q] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        fifo_full      = 1'b0;
        fifo_prog_full = 1'b0;
        clear_src();
        drive();
        tick();
        tick();
        rst = 1'b0;
        wr_log.delete();
        wr_cyc.delete();
        exp_log.delete();
        allowed   = '1;
        mask_viol = 0;
    endtask

    task automatic drain(input string tag, input int maxc);
        int n;
        n = 0;
        while (pending() > 0 && n < maxc) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, pending(), 0);
        repeat (4) tick();
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_nwr"}, wr_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), wr_log[i], exp_log[i]);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        cyc         = 0;
        full_viol   = 0;
        multi_ready = 0;
        in_valid    = '0;
        in_last     = '0;
        in_data     = '0;

        // Reset state
        do_reset();
        rst = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_din", fifo_din, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_pad", pad_count, 0);

        // Queue 0, one 4-beat packet
        do_reset();
        allowed     = 4'b0001;
        src_npkt[0] = 1;
        src_len[0]  = 4;
        drive();
        drain("s1", 40);
        for (int b = 0; b < 4; b++) exp_log.push_back(mk(0, 0, b));
        compare_log("s1");
        check("s1_span", wr_cyc[3] - wr_cyc[0], 3);
        check("s1_other_ready", mask_viol, 0);
        check("s1_pkt", pkt_count, 1);
        check("s1_pad", pad_count, 0);

        // Queue 2, one 3-beat packet (odd)
        do_reset();
        src_npkt[2] = 1;
        src_len[2]  = 3;
        drive();
        drain("s2", 40);
        for (int b = 0; b < 3; b++) exp_log.push_back(mk(2, 0, b));
`ifdef PCAP_REPLAY_FIFO_WR_ARB_PAD_EN
        exp_log.push_back('0);
        check("s2_pad_next", wr_cyc[3] - wr_cyc[2], 1);
        check("s2_pad", pad_count, 1);
`else
        check("s2_pad", pad_count, 0);
`endif
        compare_log("s2");
        check("s2_pkt", pkt_count, 1);

        // All queues, two 2-beat packets each
        do_reset();
        for (int q = 0; q < NQ; q++) begin
            src_npkt[q] = 2;
            src_len[q]  = 2;
        end
        drive();
        drain("s3", 100);
        for (int p = 0; p < 2; p++)
            for (int q = 0; q < NQ; q++)
                for (int b = 0; b < 2; b++) exp_log.push_back(mk(q, p, b));
        compare_log("s3");
        check("s3_span", wr_cyc[15] - wr_cyc[0], 22);
        check("s3_pkt", pkt_count, 8);

        // prog_full blocks grant while queue 1 requests
        do_reset();
        fifo_prog_full = 1'b1;
        allowed        = '0;
        src_npkt[1]    = 1;
        src_len[1]     = 2;
        drive();
        repeat (10) tick();
        check("s4_blocked_nwr", wr_log.size(), 0);
        check("s4_blocked_ready", mask_viol, 0);
        allowed        = '1;
        fifo_prog_full = 1'b0;
        cyc_d          = cyc;
        drain("s4", 40);
        exp_log.push_back(mk(1, 0, 0));
        exp_log.push_back(mk(1, 0, 1));
        compare_log("s4");
        check("s4_first_wr_cyc", wr_cyc[0], cyc_d + 1);
        check("s4_pkt", pkt_count, 1);

        // fifo_full pulses mid-packet and over the pad beat
        do_reset();
        src_npkt[0] = 1;
        src_len[0]  = 3;
        drive();
        for (int s = 0; s < 16; s++) begin
            fifo_full = (s >= 2 && s <= 4) || (s >= 7 && s <= 9);
            tick();
        end
        fifo_full = 1'b0;
        repeat (2) tick();
        check("s5_drain", pending(), 0);
        for (int b = 0; b < 3; b++) exp_log.push_back(mk(0, 0, b));
`ifdef PCAP_REPLAY_FIFO_WR_ARB_PAD_EN
        exp_log.push_back('0);
        check("s5_pad_cyc", wr_cyc[3] - wr_cyc[2], 4);
`endif
        compare_log("s5");
        check("s5_stall_b1", wr_cyc[1] - wr_cyc[0], 4);
        check("s5_pkt", pkt_count, 1);

        // Reset mid-packet on queue 3
        do_reset();
        src_npkt[0] = 1;
        src_len[0]  = 2;
        src_npkt[3] = 1;
        src_len[3]  = 4;
        drive();
        repeat (6) tick();
        check("s6_pre_nwr", wr_log.size(), 4);
        check("s6_pre_pkt", pkt_count, 1);
        src_hold[3] = 1'b1;
        rst         = 1'b1;
        drive();
        tick();
        rst = 1'b0;
        clear_src();
        drive();
        check("s6_ready", in_ready, 0);
        check("s6_wr_en", fifo_wr_en, 0);
        check("s6_din", fifo_din, 0);
        check("s6_pkt", pkt_count, 0);
        check("s6_pad", pad_count, 0);
        wr_log.delete();
        wr_cyc.delete();
        src_npkt[0] = 1;
        src_len[0]  = 2;
        src_pidx[0] = 5;
        src_npkt[3] = 1;
        src_len[3]  = 2;
        src_pidx[3] = 6;
        drive();
        drain("s6", 40);
        exp_log.push_back(mk(0, 5, 0));
        exp_log.push_back(mk(0, 5, 1));
        exp_log.push_back(mk(3, 6, 0));
        exp_log.push_back(mk(3, 6, 1));
        compare_log("s6");
        check("s6_post_pkt", pkt_count, 2);

        check("wr_while_full", full_viol, 0);
        check("multi_ready", multi_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_pcap_replay_fifo_wr_arb
`default_nettype wire
